// File: rtl/multicycle_defs.sv
// rtl/multicycle_defs.sv - opcode encodings, step constants and per-step control decode
package multicycle_defs;

    // Major opcodes, InsM = instruction bits [15:11]
    localparam logic [4:0] OP_ALU     = 5'b00000;
    localparam logic [4:0] OP_LHI     = 5'b00001;
    localparam logic [4:0] OP_LLI     = 5'b00010;
    localparam logic [4:0] OP_LDRRI   = 5'b00011;
    localparam logic [4:0] OP_LDRRR   = 5'b00100;
    localparam logic [4:0] OP_STRRI   = 5'b00101;
    localparam logic [4:0] OP_CMP_STR = 5'b00110;
    localparam logic [4:0] OP_ADDI    = 5'b00111;
    localparam logic [4:0] OP_SUBI    = 5'b01000;
    localparam logic [4:0] OP_MOV     = 5'b01011;
    localparam logic [4:0] OP_JMP     = 5'b10000;
    localparam logic [4:0] OP_JALRL   = 5'b10001;
    localparam logic [4:0] OP_JALRR   = 5'b10010;
    localparam logic [4:0] OP_JR      = 5'b10011;
    localparam logic [4:0] OP_BR      = 5'b11000;
    localparam logic [4:0] OP_BAL     = 5'b11001;
    localparam logic [4:0] OP_SYS     = 5'b11100;

    // Minor opcodes, InsL = instruction bits [1:0]
    localparam logic [1:0] L_STRRR = 2'b00;
    localparam logic [1:0] L_CMP   = 2'b01;
    localparam logic [1:0] L_OUTR  = 2'b00;
    localparam logic [1:0] L_HLT   = 2'b01;

    // Branch conditions, InsC = instruction bits [10:8]
    localparam logic [2:0] C_NE = 3'b000;
    localparam logic [2:0] C_EQ = 3'b001;
    localparam logic [2:0] C_CS = 3'b010;
    localparam logic [2:0] C_CC = 3'b011;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b10;

    // Step counter values
    localparam logic [2:0] CNT_FETCH  = 3'd0;
    localparam logic [2:0] CNT_DECODE = 3'd1;
    localparam logic [2:0] CNT_EXEC   = 3'd2;
    localparam logic [2:0] CNT_MEM    = 3'd3;

    // Last step per instruction length
    localparam logic [2:0] LAST_SHORT = 3'd2;
    localparam logic [2:0] LAST_MID   = 3'd3;
    localparam logic [2:0] LAST_LONG  = 3'd4;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    // Instructions grouped by identical step behaviour
    typedef enum logic [3:0] {
        CL_SET,   // LHI, LLI, MOV
        CL_CMP,
        CL_OUT,
        CL_BR,    // conditional branch and BAL
        CL_JMP,   // JMP, JR
        CL_ALU,   // ALU, ADDI, SUBI
        CL_ST,
        CL_JAL,
        CL_LD,
        CL_HLT,
        CL_ILL
    } cls_t;

    typedef struct packed {
        logic       buff_pc;
        logic       ir_ld;
        logic       pc_inc;
        logic       pc_ld;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       flag_wr;
        logic       out_en;
        logic       illegal;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE  = '{default: '0};
    localparam ctrl_t CTRL_FETCH = '{ir_ld: 1'b1, pc_inc: 1'b1, default: '0};

    function automatic cls_t classify(input logic [4:0] m, input logic [1:0] l);
        cls_t c;
        c = CL_ILL;
        case (m)
            OP_LHI, OP_LLI, OP_MOV:      c = CL_SET;
            OP_ALU, OP_ADDI, OP_SUBI:    c = CL_ALU;
            OP_LDRRI, OP_LDRRR:          c = CL_LD;
            OP_STRRI:                    c = CL_ST;
            OP_CMP_STR:                  c = (l == L_CMP) ? CL_CMP : ((l == L_STRRR) ? CL_ST : CL_ILL);
            OP_JMP, OP_JR:               c = CL_JMP;
            OP_JALRL, OP_JALRR:          c = CL_JAL;
            OP_BR, OP_BAL:               c = CL_BR;
            OP_SYS:                      c = (l == L_OUTR) ? CL_OUT : ((l == L_HLT) ? CL_HLT : CL_ILL);
            default:                     c = CL_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] last_cnt(input cls_t c);
        logic [2:0] n;
        n = LAST_SHORT;
        case (c)
            CL_ALU, CL_ST, CL_JAL: n = LAST_MID;
            CL_LD:                 n = LAST_LONG;
            default:               n = LAST_SHORT;
        endcase
        return n;
    endfunction

    // Control word for step cnt of an instruction of class c
    function automatic ctrl_t step_ctrl(input cls_t c, input logic [4:0] m, input logic [1:0] l,
                                        input logic [2:0] cnt, input logic taken);
        ctrl_t o;
        o = CTRL_IDLE;
        if (cnt == CNT_FETCH) begin
            o = CTRL_FETCH;
        end else if (cnt >= CNT_EXEC) begin
            o.buff_pc = (cnt == last_cnt(c)) && (c != CL_HLT);
            case (c)
                CL_SET: o.reg_wr = 1'b1;
                CL_CMP: begin
                    o.flag_wr = 1'b1;
                    o.alu_op  = ALU_SUB;
                end
                CL_OUT: o.out_en = 1'b1;
                CL_BR:  o.pc_ld  = taken;
                CL_JMP: o.pc_ld  = 1'b1;
                CL_ALU: begin
                    o.flag_wr = (cnt == CNT_EXEC);
                    o.reg_wr  = (cnt == LAST_MID);
                    o.alu_op  = (m == OP_ALU) ? l : ((m == OP_SUBI) ? ALU_SUB : ALU_ADD);
                end
                CL_ST:  o.mem_wr = (cnt == CNT_MEM);
                CL_JAL: begin
                    o.reg_wr = (cnt == CNT_EXEC);
                    o.pc_ld  = (cnt == LAST_MID);
                end
                CL_LD:  begin
                    o.mem_rd = (cnt == CNT_MEM);
                    o.reg_wr = (cnt == LAST_LONG);
                end
                CL_ILL: o.illegal = 1'b1;
                default: o = CTRL_IDLE;
            endcase
        end
        return o;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch taken evaluation from opcode, condition and flags
module branch_cond
    import multicycle_defs::*;
(
    input  logic [4:0] InsM,
    input  logic [2:0] InsC,
    input  logic       FlagC,
    input  logic       FlagZ,
    output logic       Taken
);

    logic cond_met;

    // Condition code against the current flags; unlisted codes never take
    always_comb begin
        cond_met = 1'b0;
        case (InsC)
            C_NE:    cond_met = !FlagZ;
            C_EQ:    cond_met = FlagZ;
            C_CS:    cond_met = FlagC;
            C_CC:    cond_met = !FlagC;
            default: cond_met = 1'b0;
        endcase
    end

    assign Taken = (InsM == OP_BAL) || ((InsM == OP_BR) && cond_met);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU step sequencer with registered control strobes
module multicycle_ctrl
    import multicycle_defs::*;
(
    input  logic       clk,
    input  logic       Rst_n,
    input  logic [4:0] InsM,
    input  logic [2:0] InsC,
    input  logic [1:0] InsL,
    input  logic       FlagC,
    input  logic       FlagZ,
    input  logic       Mem_Rdy,
    output logic [2:0] Cnt,
    output logic       Buff_PC,
    output logic       IR_Ld,
    output logic       PC_Inc,
    output logic       PC_Ld,
    output logic       Reg_Wr,
    output logic       Mem_Rd,
    output logic       Mem_Wr,
    output logic       Flag_Wr,
    output logic       Out_En,
    output logic [1:0] ALU_Op,
    output logic       Halted,
    output logic       Illegal
);

    state_t     state;
    logic [2:0] cnt_q;
    logic [4:0] op_m;
    logic [2:0] op_c;
    logic [1:0] op_l;
    ctrl_t      ctrl_q;
    logic       halted_q;

    cls_t       new_cls;
    cls_t       cur_cls;
    logic [4:0] br_m;
    logic [2:0] br_c;
    logic       taken;
    logic       mem_step;

    assign new_cls = classify(InsM, InsL);
    assign cur_cls = classify(op_m, op_l);

    // Branch decision is taken on the edge that latches the opcode; afterwards only the latched copy is seen
    assign br_m = (state == ST_DECODE) ? InsM : op_m;
    assign br_c = (state == ST_DECODE) ? InsC : op_c;

    branch_cond u_branch_cond (
        .InsM  (br_m),
        .InsC  (br_c),
        .FlagC (FlagC),
        .FlagZ (FlagZ),
        .Taken (taken)
    );

    assign mem_step = ((cur_cls == CL_LD) || (cur_cls == CL_ST)) && (cnt_q == CNT_MEM);

    // Step sequencer: outputs are registered by computing the control word of the step being entered
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_FETCH;
            cnt_q    <= CNT_FETCH;
            op_m     <= '0;
            op_c     <= '0;
            op_l     <= '0;
            ctrl_q   <= CTRL_FETCH;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    state  <= ST_DECODE;
                    cnt_q  <= CNT_DECODE;
                    ctrl_q <= CTRL_IDLE;
                end
                ST_DECODE: begin
                    op_m  <= InsM;
                    op_c  <= InsC;
                    op_l  <= InsL;
                    cnt_q <= CNT_EXEC;
                    if (new_cls == CL_HLT) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                        ctrl_q   <= CTRL_IDLE;
                    end else begin
                        state  <= ST_EXEC;
                        ctrl_q <= step_ctrl(new_cls, InsM, InsL, CNT_EXEC, taken);
                    end
                end
                ST_EXEC: begin
                    if (mem_step && !Mem_Rdy) begin
                        // Memory not ready: hold the step and its strobes
                        state <= ST_EXEC;
                    end else if (cnt_q == last_cnt(cur_cls)) begin
                        state  <= ST_FETCH;
                        cnt_q  <= CNT_FETCH;
                        ctrl_q <= CTRL_FETCH;
                    end else begin
                        cnt_q  <= cnt_q + 3'd1;
                        ctrl_q <= step_ctrl(cur_cls, op_m, op_l, cnt_q + 3'd1, taken);
                    end
                end
                ST_HALT: begin
                    // Parked until reset
                    state <= ST_HALT;
                end
                default: begin
                    state  <= ST_FETCH;
                    cnt_q  <= CNT_FETCH;
                    ctrl_q <= CTRL_FETCH;
                end
            endcase
        end
    end

    assign Cnt     = cnt_q;
    assign Buff_PC = ctrl_q.buff_pc;
    assign IR_Ld   = ctrl_q.ir_ld;
    assign PC_Inc  = ctrl_q.pc_inc;
    assign PC_Ld   = ctrl_q.pc_ld;
    assign Reg_Wr  = ctrl_q.reg_wr;
    assign Mem_Rd  = ctrl_q.mem_rd;
    assign Mem_Wr  = ctrl_q.mem_wr;
    assign Flag_Wr = ctrl_q.flag_wr;
    assign Out_En  = ctrl_q.out_en;
    assign ALU_Op  = ctrl_q.alu_op;
    assign Illegal = ctrl_q.illegal;
    assign Halted  = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       Rst_n;
    logic [4:0] InsM;
    logic [2:0] InsC;
    logic [1:0] InsL;
    logic       FlagC;
    logic       FlagZ;
    logic       Mem_Rdy;
    logic [2:0] Cnt;
    logic       Buff_PC;
    logic       IR_Ld;
    logic       PC_Inc;
    logic       PC_Ld;
    logic       Reg_Wr;
    logic       Mem_Rd;
    logic       Mem_Wr;
    logic       Flag_Wr;
    logic       Out_En;
    logic [1:0] ALU_Op;
    logic       Halted;
    logic       Illegal;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk     (clk),
        .Rst_n   (Rst_n),
        .InsM    (InsM),
        .InsC    (InsC),
        .InsL    (InsL),
        .FlagC   (FlagC),
        .FlagZ   (FlagZ),
        .Mem_Rdy (Mem_Rdy),
        .Cnt     (Cnt),
        .Buff_PC (Buff_PC),
        .IR_Ld   (IR_Ld),
        .PC_Inc  (PC_Inc),
        .PC_Ld   (PC_Ld),
        .Reg_Wr  (Reg_Wr),
        .Mem_Rd  (Mem_Rd),
        .Mem_Wr  (Mem_Wr),
        .Flag_Wr (Flag_Wr),
        .Out_En  (Out_En),
        .ALU_Op  (ALU_Op),
        .Halted  (Halted),
        .Illegal (Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an instruction during FETCH and advance to Cnt=2
    task automatic issue(input logic [4:0] m, input logic [2:0] c, input logic [1:0] l, input string tag);
        InsM = m;
        InsC = c;
        InsL = l;
        chk({tag, "_cnt0"}, {5'd0, Cnt}, 8'd0);
        chk({tag, "_irld0"}, {7'd0, IR_Ld}, 8'd1);
        step();
        chk({tag, "_cnt1"}, {5'd0, Cnt}, 8'd1);
        step();
        chk({tag, "_cnt2"}, {5'd0, Cnt}, 8'd2);
    endtask

    initial begin
        Rst_n   = 1'b0;
        InsM    = 5'd0;
        InsC    = 3'd0;
        InsL    = 2'd0;
        FlagC   = 1'b0;
        FlagZ   = 1'b0;
        Mem_Rdy = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cnt", {5'd0, Cnt}, 8'd0);
        chk("rst_irld", {7'd0, IR_Ld}, 8'd1);
        chk("rst_pcinc", {7'd0, PC_Inc}, 8'd1);
        chk("rst_halted", {7'd0, Halted}, 8'd0);
        chk("rst_regwr", {7'd0, Reg_Wr}, 8'd0);
        Rst_n = 1'b1;

        // ADD
        issue(5'b00000, 3'd0, 2'b00, "add");
        chk("add_flagwr2", {7'd0, Flag_Wr}, 8'd1);
        chk("add_regwr2", {7'd0, Reg_Wr}, 8'd0);
        chk("add_buff2", {7'd0, Buff_PC}, 8'd0);
        chk("add_aluop2", {6'd0, ALU_Op}, 8'd0);
        step();
        chk("add_cnt3", {5'd0, Cnt}, 8'd3);
        chk("add_regwr3", {7'd0, Reg_Wr}, 8'd1);
        chk("add_buff3", {7'd0, Buff_PC}, 8'd1);
        chk("add_flagwr3", {7'd0, Flag_Wr}, 8'd0);
        step();

        // SUBI forces ALU_Op=10
        issue(5'b01000, 3'd0, 2'b11, "subi");
        chk("subi_aluop", {6'd0, ALU_Op}, 8'd2);
        chk("subi_flagwr", {7'd0, Flag_Wr}, 8'd1);
        step();
        step();

        // LDRri with memory stalled for three edges
        Mem_Rdy = 1'b0;
        issue(5'b00011, 3'd0, 2'b00, "ldr");
        chk("ldr_memrd2", {7'd0, Mem_Rd}, 8'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ldr_stall_cnt%0d", i), {5'd0, Cnt}, 8'd3);
            chk($sformatf("ldr_stall_memrd%0d", i), {7'd0, Mem_Rd}, 8'd1);
            chk($sformatf("ldr_stall_regwr%0d", i), {7'd0, Reg_Wr}, 8'd0);
            if (i == 3) Mem_Rdy = 1'b1;
            step();
        end
        chk("ldr_cnt4", {5'd0, Cnt}, 8'd4);
        chk("ldr_regwr4", {7'd0, Reg_Wr}, 8'd1);
        chk("ldr_buff4", {7'd0, Buff_PC}, 8'd1);
        chk("ldr_memrd4", {7'd0, Mem_Rd}, 8'd0);
        step();

        // STRrr
        issue(5'b00110, 3'd0, 2'b00, "str");
        chk("str_memwr2", {7'd0, Mem_Wr}, 8'd0);
        step();
        chk("str_memwr3", {7'd0, Mem_Wr}, 8'd1);
        chk("str_buff3", {7'd0, Buff_PC}, 8'd1);
        step();

        // BEQ taken then not taken
        FlagZ = 1'b1;
        issue(5'b11000, 3'b001, 2'b00, "beq_t");
        chk("beq_t_pcld", {7'd0, PC_Ld}, 8'd1);
        chk("beq_t_buff", {7'd0, Buff_PC}, 8'd1);
        step();
        FlagZ = 1'b0;
        issue(5'b11000, 3'b001, 2'b00, "beq_n");
        chk("beq_n_pcld", {7'd0, PC_Ld}, 8'd0);
        chk("beq_n_buff", {7'd0, Buff_PC}, 8'd1);
        step();

        // JALrr; instruction inputs change mid-execution and must be ignored
        issue(5'b10010, 3'd0, 2'b00, "jal");
        chk("jal_regwr2", {7'd0, Reg_Wr}, 8'd1);
        chk("jal_pcld2", {7'd0, PC_Ld}, 8'd0);
        InsM = 5'b11111;
        step();
        chk("jal_cnt3", {5'd0, Cnt}, 8'd3);
        chk("jal_pcld3", {7'd0, PC_Ld}, 8'd1);
        chk("jal_buff3", {7'd0, Buff_PC}, 8'd1);
        chk("jal_regwr3", {7'd0, Reg_Wr}, 8'd0);
        step();

        // Undefined opcode
        issue(5'b11111, 3'd0, 2'b00, "ill");
        chk("ill_illegal", {7'd0, Illegal}, 8'd1);
        chk("ill_buff", {7'd0, Buff_PC}, 8'd1);
        chk("ill_regwr", {7'd0, Reg_Wr}, 8'd0);
        chk("ill_memwr", {7'd0, Mem_Wr}, 8'd0);
        chk("ill_pcld", {7'd0, PC_Ld}, 8'd0);
        step();
        chk("ill_after", {7'd0, Illegal}, 8'd0);

        // HLT, then reset out of HALT
        issue(5'b11100, 3'd0, 2'b01, "hlt");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hlt_halted%0d", i), {7'd0, Halted}, 8'd1);
            chk($sformatf("hlt_buff%0d", i), {7'd0, Buff_PC}, 8'd0);
            chk($sformatf("hlt_cnt%0d", i), {5'd0, Cnt}, 8'd2);
            chk($sformatf("hlt_irld%0d", i), {7'd0, IR_Ld}, 8'd0);
            step();
        end
        Rst_n = 1'b0;
        #1;
        chk("hlt_rst_cnt", {5'd0, Cnt}, 8'd0);
        chk("hlt_rst_halted", {7'd0, Halted}, 8'd0);
        chk("hlt_rst_irld", {7'd0, IR_Ld}, 8'd1);
        @(negedge clk);
        Rst_n = 1'b1;
        step();
        chk("post_rst_cnt1", {5'd0, Cnt}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
